// File: rtl/ram_arb_pkg.sv
// ---------------------------------------------------------------------------
// ram_arb_pkg
// Shared definitions for the two-requester RAM port arbiter:
//   - owner_e      : which requester was granted most recently
//   - DW_DEF/AW_DEF: default data/address widths (8-word x 8-bit RAM)
//   - BURST_MAX_DEF: default cap on consecutive grants under contention
//   - cnt_t        : width of the burst counter (enough for 1..15)
// ---------------------------------------------------------------------------
package ram_arb_pkg;

  localparam int DW_DEF        = 8;
  localparam int AW_DEF        = 3;
  localparam int BURST_MAX_DEF = 4;
  localparam int CNT_W         = 4;

  typedef logic [CNT_W-1:0] cnt_t;

  // Last granted requester. OWN_B is the reset value so that A wins the
  // very first contention.
  typedef enum logic {
    OWN_A = 1'b0,
    OWN_B = 1'b1
  } owner_e;

endpackage : ram_arb_pkg

// File: rtl/rr_burst_arb2.sv
// ---------------------------------------------------------------------------
// rr_burst_arb2
// Two-way round-robin arbiter with a burst limit. Grants are combinational
// from the requests; the owner FSM and the burst counter are registered.
//
// Ports:
//   clk      in   clock, all state updates on the rising edge
//   rst      in   synchronous active-high reset; forces both grants low
//   i_req_a  in   requester A wants an access this cycle
//   i_req_b  in   requester B wants an access this cycle
//   o_gnt_a  out  A granted this cycle (at most one grant is ever high)
//   o_gnt_b  out  B granted this cycle
// ---------------------------------------------------------------------------
module rr_burst_arb2
  import ram_arb_pkg::*;
#(
  parameter int BURST_MAX = BURST_MAX_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic i_req_a,
  input  logic i_req_b,
  output logic o_gnt_a,
  output logic o_gnt_b
);

  localparam cnt_t LP_BURST_MAX = cnt_t'(BURST_MAX);

  owner_e r_state;
  owner_e w_state_nxt;
  cnt_t   r_cnt;
  cnt_t   w_cnt_nxt;
  logic   w_owner_keeps;
  owner_e w_winner;

  // Next-state and grant logic.
  always_comb begin
    // NOTE: every signal written here gets a default first, so no branch can
    // leave one unassigned and infer a latch.
    o_gnt_a     = 1'b0;
    o_gnt_b     = 1'b0;
    w_winner    = r_state;
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;

    // cnt is zero only between reset and the first grant: the owner has not
    // been granted anything yet, so it has no burst to continue and the
    // other side wins. After any grant cnt is at least 1.
    w_owner_keeps = (r_cnt != '0) && (r_cnt < LP_BURST_MAX);

    if (!rst) begin
      case ({i_req_a, i_req_b})
        2'b10: o_gnt_a = 1'b1;
        2'b01: o_gnt_b = 1'b1;
        2'b11: begin
          if (r_state == OWN_A) begin
            if (w_owner_keeps) o_gnt_a = 1'b1;
            else               o_gnt_b = 1'b1;
          end else begin
            if (w_owner_keeps) o_gnt_b = 1'b1;
            else               o_gnt_a = 1'b1;
          end
        end
        default: ;
      endcase

      if (o_gnt_a || o_gnt_b) begin
        w_winner = o_gnt_a ? OWN_A : OWN_B;
        if (w_winner != r_state) begin
          w_state_nxt = w_winner;
          w_cnt_nxt   = cnt_t'(1);
        end else if (r_cnt < LP_BURST_MAX) begin
          // Saturate so a long solo run cannot wrap the counter and hand the
          // owner a fresh burst when the other side starts requesting.
          w_cnt_nxt = r_cnt + cnt_t'(1);
        end
      end
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    if (rst) begin
      r_state <= OWN_B;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

endmodule : rr_burst_arb2

// File: rtl/ram_port_arbiter.sv
// ---------------------------------------------------------------------------
// ram_port_arbiter
// Shares one single-port RAM (registered read address) between requesters
// A and B. The winning request drives the RAM port combinationally; a read
// granted at edge N returns ram_q on rdata during cycle N..N+1 with the
// owner's rvalid high. Writes commit at the grant edge and return nothing.
//
// Ports:
//   clk, rst                    clock, synchronous active-high reset
//   a_req/a_we/a_addr/a_wdata   requester A access (held until a_gnt)
//   a_gnt                       A accepted this cycle (combinational)
//   a_rvalid                    A read data valid on rdata this cycle
//   b_*                         same as A, for requester B
//   rdata                       shared read data (ram_q pass-through)
//   ram_data/ram_addr/ram_we    to the RAM; all zero when nothing is granted
//   ram_q                       from the RAM read output
// ---------------------------------------------------------------------------
module ram_port_arbiter
  import ram_arb_pkg::*;
#(
  parameter int DW        = DW_DEF,
  parameter int AW        = AW_DEF,
  parameter int BURST_MAX = BURST_MAX_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          a_req,
  input  logic          a_we,
  input  logic [AW-1:0] a_addr,
  input  logic [DW-1:0] a_wdata,
  output logic          a_gnt,
  output logic          a_rvalid,
  input  logic          b_req,
  input  logic          b_we,
  input  logic [AW-1:0] b_addr,
  input  logic [DW-1:0] b_wdata,
  output logic          b_gnt,
  output logic          b_rvalid,
  output logic [DW-1:0] rdata,
  output logic [DW-1:0] ram_data,
  output logic [AW-1:0] ram_addr,
  output logic          ram_we,
  input  logic [DW-1:0] ram_q
);

  logic   w_rd_gnt;
  logic   r_rd_pend;
  owner_e r_rd_owner;

  rr_burst_arb2 #(
    .BURST_MAX (BURST_MAX)
  ) u_arb (
    .clk     (clk),
    .rst     (rst),
    .i_req_a (a_req),
    .i_req_b (b_req),
    .o_gnt_a (a_gnt),
    .o_gnt_b (b_gnt)
  );

  // RAM port mux. The arbiter never raises both grants, so priority order
  // here is irrelevant; the idle value keeps the RAM inputs quiet.
  always_comb begin
    ram_we   = 1'b0;
    ram_addr = '0;
    ram_data = '0;
    if (a_gnt) begin
      ram_we   = a_we;
      ram_addr = a_addr;
      ram_data = a_wdata;
    end else if (b_gnt) begin
      ram_we   = b_we;
      ram_addr = b_addr;
      ram_data = b_wdata;
    end
  end

  assign w_rd_gnt = (a_gnt && !a_we) || (b_gnt && !b_we);

  // Read-return pipeline: one flag, one owner. The RAM registers the read
  // address at the grant edge, so its q is valid for exactly the next cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rd_pend  <= 1'b0;
      r_rd_owner <= OWN_A;
    end else begin
      r_rd_pend <= w_rd_gnt;
      if (a_gnt)      r_rd_owner <= OWN_A;
      else if (b_gnt) r_rd_owner <= OWN_B;
    end
  end

  assign a_rvalid = r_rd_pend && (r_rd_owner == OWN_A);
  assign b_rvalid = r_rd_pend && (r_rd_owner == OWN_B);
  assign rdata    = ram_q;

endmodule : ram_port_arbiter

// File: tb/tb_ram_port_arbiter.sv
// ---------------------------------------------------------------------------
// tb_ram_port_arbiter
// Drives ram_port_arbiter wired to a behavioural 8x8 RAM with a registered
// read address. A reference model tracks the last granted requester, the
// length of its current run of grants, a copy of the memory and the pending
// read; one compare process checks every DUT output on each falling edge.
// Directed sequences add literal expectations, then a randomized phase runs.
// ---------------------------------------------------------------------------
module tb_ram_port_arbiter;

  localparam int DW = 8;
  localparam int AW = 3;
  localparam int BM = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          a_req, a_we, b_req, b_we;
  logic [AW-1:0] a_addr, b_addr;
  logic [DW-1:0] a_wdata, b_wdata;
  logic          a_gnt, a_rvalid, b_gnt, b_rvalid;
  logic [DW-1:0] rdata, ram_data, ram_q;
  logic [AW-1:0] ram_addr;
  logic          ram_we;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  ram_port_arbiter #(
    .DW        (DW),
    .AW        (AW),
    .BURST_MAX (BM)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .a_req    (a_req),
    .a_we     (a_we),
    .a_addr   (a_addr),
    .a_wdata  (a_wdata),
    .a_gnt    (a_gnt),
    .a_rvalid (a_rvalid),
    .b_req    (b_req),
    .b_we     (b_we),
    .b_addr   (b_addr),
    .b_wdata  (b_wdata),
    .b_gnt    (b_gnt),
    .b_rvalid (b_rvalid),
    .rdata    (rdata),
    .ram_data (ram_data),
    .ram_addr (ram_addr),
    .ram_we   (ram_we),
    .ram_q    (ram_q)
  );

  // Single-port RAM: write at the edge, read address registered at the edge.
  logic [DW-1:0] ram_mem [8];
  logic [AW-1:0] ram_raddr;
  always @(posedge clk) begin
    if (ram_we) ram_mem[ram_addr] <= ram_data;
    ram_raddr <= ram_addr;
  end
  assign ram_q = ram_mem[ram_raddr];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // m_last: -1 nobody granted since reset, 0 = A, 1 = B.
  // m_run : consecutive grants to m_last (not saturated).
  int            m_last = -1;
  int            m_run  = 0;
  logic [DW-1:0] m_mem [8];
  bit            m_pend = 1'b0;
  int            m_who  = 0;
  logic [DW-1:0] m_pdata;
  bit            m_live = 1'b0;

  // Who must be granted this cycle, from the current inputs and history.
  function automatic int exp_grant();
    if (rst)              return -1;
    if (a_req && !b_req)  return 0;
    if (b_req && !a_req)  return 1;
    if (!a_req && !b_req) return -1;
    if (m_last < 0)       return 0;
    if (m_run < BM)       return m_last;
    return 1 - m_last;
  endfunction

  always @(posedge clk) begin
    int g;
    g = exp_grant();
    if (rst) begin
      m_last = -1;
      m_run  = 0;
      m_pend = 1'b0;
    end else begin
      m_pend = 1'b0;
      if (g >= 0) begin
        if (g == m_last) m_run++;
        else begin
          m_last = g;
          m_run  = 1;
        end
        if (g == 0) begin
          if (a_we) m_mem[a_addr] = a_wdata;
          else begin m_pend = 1'b1; m_who = 0; m_pdata = m_mem[a_addr]; end
        end else begin
          if (b_we) m_mem[b_addr] = b_wdata;
          else begin m_pend = 1'b1; m_who = 1; m_pdata = m_mem[b_addr]; end
        end
      end
    end
    m_live = 1'b1;
  end

  // Compare process: every output, every cycle, mid-cycle.
  always @(negedge clk) begin
    int            g;
    logic          e_we;
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_data;
    if (m_live) begin
      g      = exp_grant();
      e_we   = 1'b0;
      e_addr = '0;
      e_data = '0;
      if (g == 0) begin e_we = a_we; e_addr = a_addr; e_data = a_wdata; end
      if (g == 1) begin e_we = b_we; e_addr = b_addr; e_data = b_wdata; end
      check("a_gnt",    32'(a_gnt),    32'(g == 0));
      check("b_gnt",    32'(b_gnt),    32'(g == 1));
      check("ram_we",   32'(ram_we),   32'(e_we));
      check("ram_addr", 32'(ram_addr), 32'(e_addr));
      check("ram_data", 32'(ram_data), 32'(e_data));
      check("a_rvalid", 32'(a_rvalid), 32'(m_pend && m_who == 0));
      check("b_rvalid", 32'(b_rvalid), 32'(m_pend && m_who == 1));
      if (m_pend) check("rdata", 32'(rdata), 32'(m_pdata));
    end
  end

  // ---------------- stimulus ----------------
  task automatic set_a(input logic req, input logic we, input logic [AW-1:0] addr,
                       input logic [DW-1:0] data);
    a_req = req; a_we = we; a_addr = addr; a_wdata = data;
  endtask

  task automatic set_b(input logic req, input logic we, input logic [AW-1:0] addr,
                       input logic [DW-1:0] data);
    b_req = req; b_we = we; b_addr = addr; b_wdata = data;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    bit pat1 [10];
    bit pat2 [5];
    logic ga, gb;
    pat1 = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    pat2 = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};

    // Reset with both requesting: nothing granted, nothing returned.
    rst = 1'b1;
    set_a(1'b1, 1'b0, 3'd2, 8'h00);
    set_b(1'b1, 1'b0, 3'd5, 8'h00);
    repeat (2) begin
      @(negedge clk);
      check("rst_a_gnt",    32'(a_gnt),    32'd0);
      check("rst_b_gnt",    32'(b_gnt),    32'd0);
      check("rst_ram_we",   32'(ram_we),   32'd0);
      check("rst_a_rvalid", 32'(a_rvalid), 32'd0);
      check("rst_b_rvalid", 32'(b_rvalid), 32'd0);
      tick();
    end

    // Continuous contention: A x4, B x4, A ...; rvalid follows with 1 lag.
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("burst_a_gnt", 32'(a_gnt), 32'(pat1[i]));
      check("burst_b_gnt", 32'(b_gnt), 32'(!pat1[i]));
      if (i > 0) begin
        check("burst_a_rvalid", 32'(a_rvalid), 32'(pat1[i-1]));
        check("burst_b_rvalid", 32'(b_rvalid), 32'(!pat1[i-1]));
      end
      tick();
    end
    set_a(1'b0, 1'b0, 3'd0, 8'h00);
    set_b(1'b0, 1'b0, 3'd0, 8'h00);
    tick();

    // Solo write then read of the same address.
    set_a(1'b1, 1'b1, 3'd3, 8'hA5);
    @(negedge clk);
    check("wr_a_gnt",  32'(a_gnt),  32'd1);
    check("wr_ram_we", 32'(ram_we), 32'd1);
    tick();
    set_a(1'b1, 1'b0, 3'd3, 8'h00);
    @(negedge clk);
    check("rd_a_gnt", 32'(a_gnt), 32'd1);
    tick();
    set_a(1'b0, 1'b0, 3'd0, 8'h00);
    @(negedge clk);
    check("raw_a_rvalid", 32'(a_rvalid), 32'd1);
    check("raw_b_rvalid", 32'(b_rvalid), 32'd0);
    check("raw_rdata",    32'(rdata),    32'hA5);
    tick();

    // Preload 0 and 7, then B reads 0 and A reads 7 back to back.
    set_b(1'b1, 1'b1, 3'd0, 8'h11);
    tick();
    set_b(1'b0, 1'b0, 3'd0, 8'h00);
    set_a(1'b1, 1'b1, 3'd7, 8'h77);
    tick();
    set_a(1'b0, 1'b0, 3'd0, 8'h00);
    set_b(1'b1, 1'b0, 3'd0, 8'h00);
    tick();
    set_b(1'b0, 1'b0, 3'd0, 8'h00);
    set_a(1'b1, 1'b0, 3'd7, 8'h00);
    @(negedge clk);
    check("b2b_b_rvalid", 32'(b_rvalid), 32'd1);
    check("b2b_rdata0",   32'(rdata),    32'h11);
    tick();
    set_a(1'b0, 1'b0, 3'd0, 8'h00);
    @(negedge clk);
    check("b2b_a_rvalid", 32'(a_rvalid), 32'd1);
    check("b2b_b_idle",   32'(b_rvalid), 32'd0);
    check("b2b_rdata7",   32'(rdata),    32'h77);
    tick();

    // Edge data at the address extremes.
    set_b(1'b1, 1'b1, 3'd7, 8'hFF);
    tick();
    set_b(1'b1, 1'b1, 3'd0, 8'h00);
    tick();
    set_b(1'b0, 1'b0, 3'd0, 8'h00);
    set_a(1'b1, 1'b0, 3'd7, 8'h00);
    tick();
    set_a(1'b1, 1'b0, 3'd0, 8'h00);
    @(negedge clk);
    check("wrap_rdata7", 32'(rdata), 32'hFF);
    tick();
    set_a(1'b0, 1'b0, 3'd0, 8'h00);
    @(negedge clk);
    check("wrap_a_rvalid", 32'(a_rvalid), 32'd1);
    check("wrap_rdata0",   32'(rdata),    32'h00);
    tick();

    // Reset one cycle after a read grant: the return is dropped.
    set_a(1'b1, 1'b0, 3'd3, 8'h00);
    @(negedge clk);
    check("mid_a_gnt", 32'(a_gnt), 32'd1);
    tick();
    set_a(1'b0, 1'b0, 3'd0, 8'h00);
    rst = 1'b1;
    tick();
    @(negedge clk);
    check("mid_a_rvalid", 32'(a_rvalid), 32'd0);
    check("mid_b_rvalid", 32'(b_rvalid), 32'd0);
    tick();
    rst = 1'b0;
    // A held the last three grants before reset; a cleared owner/counter
    // must give A a full fresh burst of four before B.
    set_a(1'b1, 1'b0, 3'd1, 8'h00);
    set_b(1'b1, 1'b0, 3'd6, 8'h00);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("post_rst_a_gnt", 32'(a_gnt), 32'(pat2[i]));
      tick();
    end

    // Randomized traffic; a request is held until its grant is seen.
    for (int n = 0; n < 3000; n++) begin
      @(negedge clk);
      ga = a_gnt;
      gb = b_gnt;
      @(posedge clk);
      #1;
      rst = ($urandom_range(0, 99) == 0);
      if (!a_req || ga)
        set_a(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
              AW'($urandom), DW'($urandom));
      if (!b_req || gb)
        set_b(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
              AW'($urandom), DW'($urandom));
    end
    rst = 1'b0;
    set_a(1'b0, 1'b0, 3'd0, 8'h00);
    set_b(1'b0, 1'b0, 3'd0, 8'h00);
    repeat (3) tick();
    @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule : tb_ram_port_arbiter
